// File: rtl/text_buffer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | text_buffer_ctrl: character RAM, UART byte decoder, cursor, clear/scroll |
// | Optional: define TEXT_SCROLL_EN to scroll on newline from the last row.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module text_buffer_ctrl #(
    parameter int          COLS  = 16,
    parameter int          ROWS  = 4,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] rxData,
    input  logic       rxValid,
    output logic       rxReady,
    input  logic [5:0] charAddress,
    output logic [7:0] charOutput,
    output logic [5:0] cursorPos,
    output logic       busy,
    output logic       dirty,
    input  logic       dirtyAck
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int ADDR_W = 6;
    localparam int DEPTH  = COLS * ROWS;

    localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [COL_W-1:0]  C_COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  C_ROW_MAX = ROW_W'(ROWS - 1);
`ifdef TEXT_SCROLL_EN
    localparam logic [ADDR_W-1:0] C_ROW_STEP = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] C_SPLIT    = ADDR_W'(DEPTH - COLS);
`endif

    localparam logic [7:0] C_CR = 8'h0D;
    localparam logic [7:0] C_LF = 8'h0A;
    localparam logic [7:0] C_BS = 8'h08;
    localparam logic [7:0] C_FF = 8'h0C;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
`ifdef TEXT_SCROLL_EN
        ST_SCROLL = 2'd2,
`endif
        ST_IDLE   = 2'd1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ROW_W-1:0]   r_row, w_row_nxt;
    logic [COL_W-1:0]   r_col, w_col_nxt;
    logic               r_dirty;
    logic [7:0]         r_mem [DEPTH];

    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [7:0]         w_wdata;
    logic               w_dirty_set;
    logic               w_newline;
    logic [COL_W-1:0]   w_col_dec;
`ifdef TEXT_SCROLL_EN
    logic [ADDR_W-1:0]  w_src;
`endif

    // Renderer port is a pure combinational read and is never stalled.
    assign charOutput = r_mem[charAddress];
    assign cursorPos  = {r_row, r_col};
    assign dirty      = r_dirty;
    assign w_col_dec  = r_col - 1'b1;
`ifdef TEXT_SCROLL_EN
    assign w_src      = r_cnt + C_ROW_STEP;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_dirty <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            if (w_dirty_set)
                r_dirty <= 1'b1;
            else if (dirtyAck)
                r_dirty <= 1'b0;
        end
    end

    // Array contents are deliberately not reset; CLEAR initialises them.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_we        = 1'b0;
        w_waddr     = r_cnt;
        w_wdata     = BLANK;
        w_dirty_set = 1'b0;
        w_newline   = 1'b0;
        rxReady     = 1'b0;
        busy        = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                busy      = 1'b1;
                w_we      = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_LAST) begin
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_dirty_set = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_IDLE: begin
                rxReady = 1'b1;
                if (rxValid) begin
                    if (rxData >= 8'h20 && rxData <= 8'h7E) begin
                        w_we        = 1'b1;
                        w_waddr     = {r_row, r_col};
                        w_wdata     = rxData;
                        w_dirty_set = 1'b1;
                        if (r_col == C_COL_MAX)
                            w_newline = 1'b1;
                        else
                            w_col_nxt = r_col + 1'b1;
                    end else begin
                        case (rxData)
                            C_CR: w_col_nxt = '0;
                            C_LF: w_newline = 1'b1;
                            C_BS: begin
                                if (r_col != '0) begin
                                    w_col_nxt   = w_col_dec;
                                    w_we        = 1'b1;
                                    w_waddr     = {r_row, w_col_dec};
                                    w_dirty_set = 1'b1;
                                end
                            end
                            C_FF: begin
                                w_state_nxt = ST_CLEAR;
                                w_cnt_nxt   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

`ifdef TEXT_SCROLL_EN
            ST_SCROLL: begin
                busy      = 1'b1;
                w_we      = 1'b1;
                w_wdata   = (r_cnt < C_SPLIT) ? r_mem[w_src] : BLANK;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_LAST) begin
                    w_row_nxt   = C_ROW_MAX;
                    w_col_nxt   = '0;
                    w_dirty_set = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`endif

            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase

        // Newline: next row, or last-row handling (scroll or wrap to top-left).
        if (w_newline) begin
            if (r_row != C_ROW_MAX) begin
                w_row_nxt = r_row + 1'b1;
                w_col_nxt = '0;
            end else begin
`ifdef TEXT_SCROLL_EN
                w_state_nxt = ST_SCROLL;
                w_cnt_nxt   = '0;
`else
                w_row_nxt = '0;
                w_col_nxt = '0;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_text_buffer_ctrl: directed self-checking bench for text_buffer_ctrl.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_text_buffer_ctrl;

    logic       clk;
    logic       rstn;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;
    logic [5:0] charAddress;
    logic [7:0] charOutput;
    logic [5:0] cursorPos;
    logic       busy;
    logic       dirty;
    logic       dirtyAck;

    int n_vec = 0;
    int n_err = 0;

    text_buffer_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .rxData      (rxData),
        .rxValid     (rxValid),
        .rxReady     (rxReady),
        .charAddress (charAddress),
        .charOutput  (charOutput),
        .cursorPos   (cursorPos),
        .busy        (busy),
        .dirty       (dirty),
        .dirtyAck    (dirtyAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input int a, input logic [7:0] e);
        charAddress = 6'(a);
        #1;
        chk($sformatf("mem[%0d]", a), 32'(charOutput), 32'(e));
    endtask

    task automatic send(input logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        step();
        rxValid = 1'b0;
    endtask

    task automatic ack();
        dirtyAck = 1'b1;
        step();
        dirtyAck = 1'b0;
    endtask

    // Counts samples with busy high, bounded so a stuck DUT cannot hang the run.
    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'd64);
    endtask

    task automatic chk_all_blank(input string tag);
        for (int i = 0; i < 64; i++) chk_mem(i, 8'h20);
        chk({tag, " cursor"}, 32'(cursorPos), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; rxData = 8'h00; rxValid = 1'b0; dirtyAck = 1'b0; charAddress = 6'd0;
        step();
        step();
        chk("rst busy", 32'(busy), 32'd1);
        chk("rst rxReady", 32'(rxReady), 32'd0);
        chk("rst cursor", 32'(cursorPos), 32'd0);
        chk("rst dirty", 32'(dirty), 32'd0);

        // Power-up clear
        rstn = 1'b1;
        wait_busy("init clear cycles");
        chk("init rxReady", 32'(rxReady), 32'd1);
        chk("init dirty", 32'(dirty), 32'd1);
        chk_all_blank("init");

        // Back-to-back printable bytes, ack collides with second write
        ack();
        chk("ack clears dirty", 32'(dirty), 32'd0);
        rxData = 8'h41; rxValid = 1'b1;
        step();
        chk("b2b rxReady", 32'(rxReady), 32'd1);
        rxData = 8'h42; dirtyAck = 1'b1;
        step();
        rxValid = 1'b0; dirtyAck = 1'b0;
        chk("set wins over ack", 32'(dirty), 32'd1);
        chk("cursor after AB", 32'(cursorPos), 32'd2);
        chk_mem(0, 8'h41);
        chk_mem(1, 8'h42);

        // Control codes
        send(8'h08);
        chk("BS cursor", 32'(cursorPos), 32'd1);
        chk_mem(1, 8'h20);
        ack();
        send(8'h0D);
        chk("CR cursor", 32'(cursorPos), 32'd0);
        send(8'h08);
        chk("BS col0 cursor", 32'(cursorPos), 32'd0);
        chk("BS col0 dirty", 32'(dirty), 32'd0);
        chk_mem(0, 8'h41);
        send(8'h07);
        chk("other code cursor", 32'(cursorPos), 32'd0);
        send(8'h0A);
        chk("LF cursor", 32'(cursorPos), 32'd16);

        // Fill row 1, wrap at col 15 to row 2
        for (int i = 0; i < 16; i++) send(8'(8'h30 + i));
        chk("row1 wrap cursor", 32'(cursorPos), 32'd32);
        for (int i = 0; i < 16; i++) chk_mem(16 + i, 8'(8'h30 + i));

        // Row 3 content, then printable at cursor 63
        send(8'h0A);
        chk("LF to row3", 32'(cursorPos), 32'd48);
        for (int i = 0; i < 15; i++) send(8'(8'h61 + i));
        chk("cursor 63", 32'(cursorPos), 32'd63);
        ack();
        send(8'h5A);
        chk_mem(63, 8'h5A);
`ifdef TEXT_SCROLL_EN
        chk("scroll busy", 32'(busy), 32'd1);
        wait_busy("scroll cycles");
        chk("scroll cursor", 32'(cursorPos), 32'd48);
        chk("scroll dirty", 32'(dirty), 32'd1);
        for (int i = 0; i < 16; i++) chk_mem(i, 8'(8'h30 + i));
        for (int i = 0; i < 16; i++) chk_mem(16 + i, 8'h20);
        for (int i = 0; i < 15; i++) chk_mem(32 + i, 8'(8'h61 + i));
        chk_mem(47, 8'h5A);
        for (int i = 48; i < 64; i++) chk_mem(i, 8'h20);
`else
        chk("wrap busy", 32'(busy), 32'd0);
        chk("wrap cursor", 32'(cursorPos), 32'd0);
        chk("wrap dirty", 32'(dirty), 32'd1);
        for (int i = 0; i < 16; i++) chk_mem(16 + i, 8'(8'h30 + i));
        for (int i = 0; i < 15; i++) chk_mem(48 + i, 8'(8'h61 + i));
`endif

        // Form feed over non-blank content
        ack();
        send(8'h0C);
        chk("FF rxReady", 32'(rxReady), 32'd0);
        wait_busy("FF clear cycles");
        chk("FF dirty", 32'(dirty), 32'd1);
        chk_all_blank("FF");

        // Reset in the middle of a multi-cycle operation
`ifdef TEXT_SCROLL_EN
        send(8'h0A);
        send(8'h0A);
        send(8'h0A);
        chk("pre-scroll cursor", 32'(cursorPos), 32'd48);
        send(8'h0A);
`else
        send(8'h0C);
`endif
        for (int i = 0; i < 20; i++) step();
        chk("mid-op busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd1);
        chk("midrst rxReady", 32'(rxReady), 32'd0);
        chk("midrst cursor", 32'(cursorPos), 32'd0);
        chk("midrst dirty", 32'(dirty), 32'd0);
        step();
        step();
        rstn = 1'b1;
        wait_busy("post-reset clear cycles");
        chk("post-reset dirty", 32'(dirty), 32'd1);
        chk_all_blank("post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
